// File: rtl/seg_bus_decoder_pkg.sv
// Shared constants for the seven-segment bus monitor: output codes, glyph table,
// and segment bit positions within one digit field.
package seg_pkg;
  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_DASH  = 5'd17;
  localparam logic [4:0] CODE_BAD   = 5'd31;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // bits g..a, active-low, indexed by hex value
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {S_WAIT, S_SCAN, S_DONE} state_t;
endpackage

// File: rtl/seg_bus_decoder_if.sv
// Segment bus plus decoded readout; master drives the displays, slave is the monitor.
interface seg_bus_if #(parameter int NUM_DIGITS = 6);
  logic [8*NUM_DIGITS-1:0] HEX;
  logic [5*NUM_DIGITS-1:0] DIGITS;
  logic [NUM_DIGITS-1:0]   DP;
  logic                    VALID;
  logic                    ERR;
  logic                    BUSY;

  modport master (output HEX, input DIGITS, DP, VALID, ERR, BUSY);
  modport slave  (input HEX, output DIGITS, DP, VALID, ERR, BUSY);
endinterface

// File: rtl/seg_bus_decoder_glyph_decode.sv
// Combinational decode of one active-low digit field into a character code and dp flag.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [7:0] pat,
  output logic [4:0] code,
  output logic       dp
);
  logic [6:0] seg7;

  assign seg7 = {pat[SEG_G], pat[SEG_F], pat[SEG_E], pat[SEG_D],
                 pat[SEG_C], pat[SEG_B], pat[SEG_A]};

  always_comb begin
    code = CODE_BAD;
    for (int i = 0; i < 16; i++)
      if (seg7 == GLYPH[i]) code = 5'(i);
    if (seg7 == 7'h7F) code = CODE_BLANK;
    if (seg7 == 7'h3F) code = CODE_DASH;
    dp = ~pat[SEG_DP];
  end
endmodule

// File: rtl/seg_bus_decoder.sv
// Seven-segment bus monitor: synchronises the bus, waits for a stable pattern,
// then scans one digit per cycle through a shared decoder and publishes the result.
module seg_bus_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 16
) (
  input  logic     CLOCK_50,
  input  logic     RESET_N,
  seg_bus_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][7:0] sync1, sync2, snap, last;
  logic [CW-1:0]              cnt;
  logic                       first;
  state_t                     state, state_nxt;
  logic [IW-1:0]              idx, idx_nxt;
  logic [NUM_DIGITS-1:0][4:0] shadow, digits;
  logic [NUM_DIGITS-1:0]      shadow_dp, dp;
  logic                       valid, err;
  logic                       change, scan_en, load_out, bad_any;
  logic [4:0]                 code;
  logic                       gdp;

  assign change = (sync2 != snap);

  seg_glyph_decode u_dec (.pat(snap[idx]), .code(code), .dp(gdp));

  always_comb begin
    bad_any = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (shadow[i] == CODE_BAD) bad_any = 1'b1;
  end

  // A snapshot change overrides every state, including a pending DONE.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    scan_en   = 1'b0;
    load_out  = 1'b0;
    if (change) begin
      state_nxt = S_WAIT;
    end else begin
      case (state)
        S_WAIT: if (cnt == CNT_MAX && (snap != last || first)) begin
          state_nxt = S_SCAN;
          idx_nxt   = '0;
        end
        S_SCAN: begin
          scan_en = 1'b1;
          if (idx == IDX_LAST) state_nxt = S_DONE;
          else                 idx_nxt   = idx + IW'(1);
        end
        S_DONE: begin
          load_out  = 1'b1;
          state_nxt = S_WAIT;
        end
        default: state_nxt = S_WAIT;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sync1     <= '1;
      sync2     <= '1;
      snap      <= '1;
      last      <= '1;
      cnt       <= '0;
      first     <= 1'b1;
      state     <= S_WAIT;
      idx       <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      digits    <= '0;
      dp        <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
    end else begin
      sync1 <= bus.HEX;
      sync2 <= sync1;
      state <= state_nxt;
      idx   <= idx_nxt;
      valid <= load_out;
      if (change) begin
        snap <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
      if (scan_en) begin
        shadow[idx]    <= code;
        shadow_dp[idx] <= gdp;
      end
      if (load_out) begin
        digits <= shadow;
        dp     <= shadow_dp;
        err    <= bad_any;
        last   <= snap;
        first  <= 1'b0;
      end
    end
  end

  assign bus.DIGITS = digits;
  assign bus.DP     = dp;
  assign bus.VALID  = valid;
  assign bus.ERR    = err;
  assign bus.BUSY   = (state == S_SCAN);
endmodule

// File: tb/tb_seg_bus_decoder.sv
// Scenario bench for seg_bus_decoder: expected readouts are queued when a pattern
// is driven and popped when VALID pulses.
module tb_seg_bus_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg_bus_if #(.NUM_DIGITS(6)) bus ();

  seg_bus_decoder #(.NUM_DIGITS(6), .STABLE_CYCLES(16)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] digits;
    logic [5:0]  dp;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   valid_count = 0;
  int   busy_run = 0;
  int   last_busy = 0;
  bit   busy_q = 0, valid_q = 0, dbl_valid = 0;

  always @(negedge clk) begin
    if (bus.BUSY && !busy_q) busy_run = 1;
    else if (bus.BUSY)       busy_run++;
    if (bus.VALID) begin
      valid_count++;
      last_busy = busy_run;
      if (valid_q) dbl_valid = 1;
    end
    busy_q  = bus.BUSY;
    valid_q = bus.VALID;
  end

  task automatic wait_valid(input int limit, output bit found, output int n);
    found = 0;
    n = 0;
    while (!found && n < limit) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (bus.VALID) found = 1;
    end
    #1;
  endtask

  task automatic wait_busy(input int limit, output bit found);
    found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (bus.BUSY) found = 1;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    bit found;
    int n;
    rst_n = 0;
    bus.HEX = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (bus.VALID !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", bus.VALID); end
    tests++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", bus.BUSY); end
    tests++; if ({bus.DIGITS, bus.DP, bus.ERR} !== 37'd0) begin
      fails++; $display("FAIL rst_outputs got %h/%b/%b want 0", bus.DIGITS, bus.DP, bus.ERR); end
    rst_n = 1;
    bus.HEX = {6{8'hC0}};
    exp_q.push_back('{digits: {6{5'd0}}, dp: 6'b0, err: 1'b0});
    wait_valid(60, found, n);
    tests++; if (!found || n != 26) begin fails++; $display("FAIL zeros_latency got %0d found %b want 26", n, found); end
    e = exp_q.pop_front();
    tests++; if ({bus.DIGITS, bus.DP, bus.ERR} !== e) begin
      fails++; $display("FAIL zeros_data got %h/%b/%b want %h/%b/%b", bus.DIGITS, bus.DP, bus.ERR, e.digits, e.dp, e.err); end
    tests++; if (last_busy != 6) begin fails++; $display("FAIL zeros_busy got %0d want 6", last_busy); end
  endtask

  task automatic test_blank_dp();
    exp_t e;
    bit found;
    int n;
    @(negedge clk);
    bus.HEX = {{5{8'hFF}}, 8'h40};
    exp_q.push_back('{digits: {{5{5'd16}}, 5'd0}, dp: 6'b000001, err: 1'b0});
    wait_valid(60, found, n);
    tests++; if (!found || n != 26) begin fails++; $display("FAIL blank_latency got %0d found %b want 26", n, found); end
    e = exp_q.pop_front();
    tests++; if ({bus.DIGITS, bus.DP, bus.ERR} !== e) begin
      fails++; $display("FAIL blank_data got %h/%b/%b want %h/%b/%b", bus.DIGITS, bus.DP, bus.ERR, e.digits, e.dp, e.err); end
  endtask

  task automatic test_bad_dash();
    exp_t e;
    bit found;
    int n;
    @(negedge clk);
    bus.HEX = {8'hBF, 8'hBF, 8'hB6, 8'hBF, 8'hBF, 8'hBF};
    exp_q.push_back('{digits: {5'd17, 5'd17, 5'd31, 5'd17, 5'd17, 5'd17}, dp: 6'b0, err: 1'b1});
    wait_valid(60, found, n);
    tests++; if (!found) begin fails++; $display("FAIL bad_timeout got none want VALID"); end
    e = exp_q.pop_front();
    tests++; if ({bus.DIGITS, bus.DP, bus.ERR} !== e) begin
      fails++; $display("FAIL bad_data got %h/%b/%b want %h/%b/%b", bus.DIGITS, bus.DP, bus.ERR, e.digits, e.dp, e.err); end
  endtask

  task automatic test_unstable();
    exp_t e;
    bit found;
    int n, v0;
    v0 = valid_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.HEX = {6{8'(i * 16 + 3)}};
      repeat (9) @(negedge clk);
    end
    tests++; if (valid_count != v0) begin fails++; $display("FAIL unstable_quiet got %0d want 0", valid_count - v0); end
    @(negedge clk);
    bus.HEX = {6{8'hF9}};
    exp_q.push_back('{digits: {6{5'd1}}, dp: 6'b0, err: 1'b0});
    wait_valid(60, found, n);
    e = exp_q.pop_front();
    tests++; if (!found || {bus.DIGITS, bus.DP, bus.ERR} !== e) begin
      fails++; $display("FAIL unstable_data got %h/%b/%b found %b want %h/%b/%b", bus.DIGITS, bus.DP, bus.ERR, found, e.digits, e.dp, e.err); end
    repeat (40) @(negedge clk);
    tests++; if (valid_count - v0 != 1) begin fails++; $display("FAIL unstable_count got %0d want 1", valid_count - v0); end
  endtask

  task automatic test_glitch();
    exp_t e;
    bit found;
    int n, v0;
    @(negedge clk);
    bus.HEX = {6{8'h8E}};
    exp_q.push_back('{digits: {6{5'd15}}, dp: 6'b0, err: 1'b0});
    wait_valid(60, found, n);
    e = exp_q.pop_front();
    tests++; if (!found || {bus.DIGITS, bus.DP, bus.ERR} !== e) begin
      fails++; $display("FAIL glitch_first got %h/%b/%b found %b want %h/%b/%b", bus.DIGITS, bus.DP, bus.ERR, found, e.digits, e.dp, e.err); end
    v0 = valid_count;
    bus.HEX = {6{8'h80}};
    repeat (3) @(negedge clk);
    bus.HEX = {6{8'h8E}};
    repeat (60) @(negedge clk);
    tests++; if (valid_count != v0) begin fails++; $display("FAIL glitch_rereport got %0d want 0", valid_count - v0); end
    tests++; if (bus.DIGITS !== {6{5'd15}}) begin fails++; $display("FAIL glitch_hold got %h want %h", bus.DIGITS, {6{5'd15}}); end
  endtask

  task automatic test_abort_change();
    exp_t e;
    bit found;
    int n, v0;
    v0 = valid_count;
    @(negedge clk);
    bus.HEX = {6{8'h99}};
    wait_busy(40, found);
    tests++; if (!found) begin fails++; $display("FAIL abort_busy got none want BUSY"); end
    repeat (2) @(negedge clk);
    bus.HEX = {6{8'hA4}};
    exp_q.push_back('{digits: {6{5'd2}}, dp: 6'b0, err: 1'b0});
    wait_valid(80, found, n);
    tests++; if (!found || n != 26) begin fails++; $display("FAIL abort_latency got %0d found %b want 26", n, found); end
    e = exp_q.pop_front();
    tests++; if ({bus.DIGITS, bus.DP, bus.ERR} !== e) begin
      fails++; $display("FAIL abort_data got %h/%b/%b want %h/%b/%b", bus.DIGITS, bus.DP, bus.ERR, e.digits, e.dp, e.err); end
    tests++; if (valid_count - v0 != 1) begin fails++; $display("FAIL abort_count got %0d want 1", valid_count - v0); end
  endtask

  task automatic test_abort_reset();
    exp_t e;
    bit found;
    int n, v0;
    v0 = valid_count;
    @(negedge clk);
    bus.HEX = {6{8'h92}};
    wait_busy(40, found);
    tests++; if (!found) begin fails++; $display("FAIL rstscan_busy got none want BUSY"); end
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    tests++; if ({bus.DIGITS, bus.DP, bus.ERR, bus.VALID, bus.BUSY} !== 39'd0) begin
      fails++; $display("FAIL rstscan_outputs got %h/%b/%b/%b/%b want 0", bus.DIGITS, bus.DP, bus.ERR, bus.VALID, bus.BUSY); end
    @(negedge clk);
    rst_n = 1;
    exp_q.push_back('{digits: {6{5'd5}}, dp: 6'b0, err: 1'b0});
    wait_valid(60, found, n);
    tests++; if (!found || n != 26) begin fails++; $display("FAIL rstscan_latency got %0d found %b want 26", n, found); end
    e = exp_q.pop_front();
    tests++; if ({bus.DIGITS, bus.DP, bus.ERR} !== e) begin
      fails++; $display("FAIL rstscan_data got %h/%b/%b want %h/%b/%b", bus.DIGITS, bus.DP, bus.ERR, e.digits, e.dp, e.err); end
    tests++; if (valid_count - v0 != 1) begin fails++; $display("FAIL rstscan_count got %0d want 1", valid_count - v0); end
  endtask

  initial begin
    bus.HEX = '1;
    test_reset();
    test_blank_dp();
    test_bad_dash();
    test_unstable();
    test_glitch();
    test_abort_change();
    test_abort_reset();
    tests++; if (dbl_valid) begin fails++; $display("FAIL valid_double got 1 want 0"); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL queue_left got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
